// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt controller: synchronises interrupt lines, arbitrates
// interrupt / synchronous exception / ERET, then sequences commit, flush and PC redirect.
module exception_ctrl #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          NUM_EXC      = 8,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_HW_INT-1:0]  hw_int,
  input  logic [1:0]             sw_ip,
  input  logic [NUM_EXC-1:0]     exc_req,
  input  logic [5*NUM_EXC-1:0]   exc_code_tbl,
  input  logic                   inst_valid,
  input  logic [31:0]            inst_pc,
  input  logic                   in_delay_slot,
  input  logic                   is_eret,
  input  logic [31:0]            cp0_status,
  input  logic [31:0]            cp0_epc,
  output logic [7:0]             ip_pending,
  output logic                   commit_exc,
  output logic                   commit_eret,
  output logic [4:0]             commit_code,
  output logic [31:0]            commit_epc,
  output logic                   commit_bd,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  input  logic                   redirect_ready
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;
  typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_ERET} event_t;

  logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] r_sync;
  logic [5:0]  w_hw_ip;
  logic        w_int_take;
  logic        w_exc_hit;
  logic [4:0]  w_exc_code;
  event_t      w_event;
  logic [4:0]  w_code;
  logic [31:0] w_target;
  logic [31:0] w_epc;
  logic        w_unused_status;

  state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic        r_commit_exc;
  logic        r_commit_eret;
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic        r_bd;
  logic        r_flush;
  logic        r_redirect_valid;
  logic [31:0] r_target;

  // NOTE: the synchroniser chain is a handful of flops, not a RAM, so it is
  // reset like any other state to guarantee no stale interrupt after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      r_sync[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_hw_ip = '0;
    w_hw_ip[NUM_HW_INT-1:0] = r_sync[SYNC_STAGES-1];
  end

  assign ip_pending      = {w_hw_ip, sw_ip};
  assign w_int_take      = (|(ip_pending & cp0_status[15:8])) && cp0_status[0] && !cp0_status[1];
  assign w_epc           = in_delay_slot ? (inst_pc - 32'd4) : inst_pc;
  assign w_unused_status = ^{cp0_status[31:16], cp0_status[7:2]};

  // Walk from the highest index down so the lowest set request is the last to land.
  always_comb begin
    w_exc_hit  = 1'b0;
    w_exc_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        w_exc_hit  = 1'b1;
        w_exc_code = exc_code_tbl[5*i +: 5];
      end
    end
  end

  always_comb begin
    w_event  = EV_NONE;
    w_code   = '0;
    w_target = EXC_VECTOR;
    if (inst_valid) begin
      if (w_int_take) begin
        w_event = EV_EXC;
      end else if (w_exc_hit) begin
        w_event = EV_EXC;
        w_code  = w_exc_code;
      end else if (is_eret) begin
        w_event  = EV_ERET;
        w_target = cp0_epc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_commit_exc     <= 1'b0;
      r_commit_eret    <= 1'b0;
      r_code           <= '0;
      r_epc            <= '0;
      r_bd             <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_target         <= '0;
    end else begin
      r_commit_exc  <= 1'b0;
      r_commit_eret <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_event != EV_NONE) begin
            r_commit_exc  <= (w_event == EV_EXC);
            r_commit_eret <= (w_event == EV_ERET);
            r_code        <= w_code;
            r_epc         <= w_epc;
            r_bd          <= in_delay_slot;
            r_target      <= w_target;
            r_flush       <= 1'b1;
            r_cnt         <= CNT_W'(1);
            r_state       <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_cnt == CNT_W'(FLUSH_CYCLES)) begin
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIRECT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign commit_exc     = r_commit_exc;
  assign commit_eret    = r_commit_eret;
  assign commit_code    = r_code;
  assign commit_epc     = r_epc;
  assign commit_bd      = r_bd;
  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_target;

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Registered, parametrised exception/interrupt controller for the MIPS core's MEM-stage commit point. It synchronises hardware interrupt lines and arbitrates interrupts, a configurable set of synchronous exception requests, and ERET. A small FSM sequences commit, pipeline flush and PC redirect to the fetch unit with a valid/ready handshake. It replaces the purely combinational exception-type encoder and drives CP0 write-back directly.

## Interface
- NUM_HW_INT, 6: external interrupt lines, mapped to Cause.IP[2+i]; legal 1..6, unused IP bits read 0.
- SYNC_STAGES, 2: synchroniser flops per hw_int line; legal ≥1.
- NUM_EXC, 8: synchronous exception sources; index 0 is highest priority.
- EXC_VECTOR, 32'hBFC0_0380: handler entry PC.
- FLUSH_CYCLES, 1: cycles flush is held; legal ≥1.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- hw_int  in  NUM_HW_INT  asynchronous interrupt lines, level-sensitive.
- sw_ip  in  2  Cause.IP[1:0] from CP0.
- exc_req  in  NUM_EXC  synchronous exception requests for the MEM-stage instruction.
- exc_code_tbl  in  5*NUM_EXC  ExcCode per source, bits [5i+4:5i].
- inst_valid  in  1  MEM stage holds a real instruction.
- inst_pc  in  32  PC of that instruction.
- in_delay_slot  in  1  instruction is in a branch delay slot.
- is_eret  in  1  instruction is ERET.
- cp0_status  in  32  Status; uses IM[15:8], EXL[1], IE[0].
- cp0_epc  in  32  current EPC.
- ip_pending  out  8  synchronised {hw IP, sw_ip} for Cause.IP.
- commit_exc  out  1  one-cycle pulse: CP0 writes EPC/Cause.ExcCode/BD and sets EXL.
- commit_eret  out  1  one-cycle pulse: CP0 clears EXL.
- commit_code  out  5  ExcCode (0 = interrupt).
- commit_epc  out  32  EPC to write.
- commit_bd  out  1  Cause.BD to write.
- flush  out  1  flush IF..MEM.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new fetch PC.
- redirect_ready  in  1  fetch accepts redirect.

## Operation
- Synchroniser: each hw_int bit passes through SYNC_STAGES flops. ip_pending = {zero-extended sync'd hw bits in [7:2], sw_ip}.
- int_take = |(ip_pending & Status.IM) && IE && !EXL.
- Arbitration, evaluated only in IDLE with inst_valid=1, highest first:
  - int_take → code 0.
  - lowest-index set exc_req bit i → code exc_code_tbl[i].
  - is_eret → ERET.
  - otherwise no event.
- With inst_valid=0 nothing is taken; interrupts wait for a valid instruction.
- EPC = in_delay_slot ? inst_pc−4 : inst_pc (32-bit wrap); BD = in_delay_slot.
- Redirect target: EXC_VECTOR for exceptions and interrupts; cp0_epc as sampled in the detection cycle for ERET.
- Detection registers code, EPC, BD, event kind and target; registers hold until the next event.
- FSM states:
  - IDLE → FLUSH on event.
  - FLUSH counts FLUSH_CYCLES, then → REDIRECT.
  - REDIRECT → IDLE when redirect_valid && redirect_ready.
- New events are ignored outside IDLE.
- A synchronous exception is taken even when EXL=1 (same commit); interrupts are masked by EXL.

## Timing
- Reset (resetn low, asynchronous): state IDLE; all outputs 0; synchroniser flops, counter and capture registers cleared. Reset mid-sequence aborts with no pulse or redirect.
- hw_int→ip_pending latency: SYNC_STAGES cycles.
- Event sampled at edge T:
  - Cycles T+1..T+FLUSH_CYCLES: flush=1.
  - Cycle T+1 only: commit_exc or commit_eret =1.
  - From T+FLUSH_CYCLES+1: redirect_valid=1, redirect_pc stable until the handshake cycle inclusive.
  - redirect_ready low stalls in REDIRECT with flush=0.
- After handshake, IDLE the next cycle; a new event can be sampled at that edge.
- commit_code/commit_epc/commit_bd are valid during the pulse and held afterwards.

## Test plan
- Reset with hw_int=6'h3F held → all outputs 0. Release resetn, IM=8'hFF, IE=1, EXL=0, inst_valid=1, inst_pc=32'h8000_0010 → commit_exc with code 0, EPC 32'h8000_0010, redirect_pc 32'hBFC0_0380. Pulse timing per Timing: SYNC_STAGES cycles from hw_int to ip_pending, then detection at the next edge.
- exc_req=8'b0001_0100, exc_code_tbl[2]=5'h08, in_delay_slot=1, inst_pc=32'h8000_0104 → code 5'h08, EPC 32'h8000_0100, BD=1. flush high exactly FLUSH_CYCLES cycles.
- is_eret=1, cp0_epc=32'h8000_0200, no exceptions pending → commit_eret pulse, commit_exc=0, redirect_pc 32'h8000_0200.
- Interrupt pending plus exc_req[0] in the same cycle → interrupt wins, code 0. Repeat with EXL=1 → exception wins.
- redirect_ready held low 5 cycles while exc_req toggles → redirect_valid stays 1, no second commit. Handshake then completes and the FSM returns to IDLE.
- resetn asserted during FLUSH → all outputs 0 immediately. No redirect follows after release.
